// File: rtl/psum_accum_writeback_if.sv
// rtl/psum_accum_writeback_if.sv - OFIFO drain and psum SRAM port bundle for the writeback engine
interface psum_accum_writeback_if #(
   parameter int NUM_CH  = 16,
   parameter int COL     = 8,
   parameter int PSUM_BW = 16,
   parameter int ADDR_W  = 11
);
   localparam int DW = COL * PSUM_BW;

   logic [NUM_CH-1:0]    ch_valid;
   logic [NUM_CH*DW-1:0] ch_data;
   logic [NUM_CH-1:0]    ch_rd;
   logic                 sram_cen;
   logic                 sram_wen;
   logic [ADDR_W-1:0]    sram_addr;
   logic [DW-1:0]        sram_d;
   logic [DW-1:0]        sram_q;

   modport master (
      input  ch_valid, ch_data, sram_q,
      output ch_rd, sram_cen, sram_wen, sram_addr, sram_d
   );

   modport slave (
      output ch_valid, ch_data, sram_q,
      input  ch_rd, sram_cen, sram_wen, sram_addr, sram_d
   );
endinterface

// File: rtl/psum_accum_writeback.sv
// rtl/psum_accum_writeback.sv - drains corelet OFIFOs into psum SRAM, overwrite or saturating accumulate
module psum_accum_writeback #(
   parameter int NUM_CH  = 16,
   parameter int COL     = 8,
   parameter int PSUM_BW = 16,
   parameter int ADDR_W  = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  acc_mode,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W-1:0]     num_vec,
   psum_accum_writeback_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf
);
   localparam int DW = COL * PSUM_BW;
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_POP, S_RD, S_WR, S_FIN} state_t;

   state_t              state, state_nx;
   logic                mode_q;
   logic [ADDR_W-1:0]   num_vec_q;
   logic [ADDR_W-1:0]   v_cnt;
   logic [CW-1:0]       c_cnt;
   logic [ADDR_W-1:0]   elem_addr;
   logic [DW-1:0]       cap_data;

   logic [DW-1:0]       ch_vec [NUM_CH];
   logic                cur_valid;
   logic                last_elem;
   logic                accept;
   logic [DW-1:0]       acc_sum;
   logic [COL-1:0]      lane_sat;

   logic [NUM_CH-1:0]   ch_rd_nx;
   logic                cen_nx;
   logic                wen_nx;
   logic [ADDR_W-1:0]   addr_nx;
   logic [DW-1:0]       d_nx;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign ch_vec[g] = bus.ch_data[g*DW +: DW];
   end

   // Sign-extend by one bit; a sum whose top two bits disagree left the lane's range.
   for (genvar l = 0; l < COL; l++) begin : g_lane
      logic [PSUM_BW-1:0] a;
      logic [PSUM_BW-1:0] b;
      logic [PSUM_BW:0]   s;
      assign a = cap_data[l*PSUM_BW +: PSUM_BW];
      assign b = bus.sram_q[l*PSUM_BW +: PSUM_BW];
      assign s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
      assign lane_sat[l] = s[PSUM_BW] ^ s[PSUM_BW-1];
      assign acc_sum[l*PSUM_BW +: PSUM_BW] = !lane_sat[l] ? s[PSUM_BW-1:0] :
                                             (s[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                                         : {1'b0, {(PSUM_BW-1){1'b1}}});
   end

   assign cur_valid = bus.ch_valid[c_cnt];
   assign last_elem = (v_cnt == num_vec_q - ADDR_W'(1)) && (c_cnt == CW'(NUM_CH - 1));
   assign accept    = (state == S_IDLE) && start && !abort;

   always_comb begin
      state_nx = state;
      ch_rd_nx = '0;
      cen_nx   = 1'b1;
      wen_nx   = 1'b1;
      addr_nx  = '0;
      d_nx     = '0;
      done     = 1'b0;
      busy     = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nx = (num_vec == '0) ? S_FIN : S_POP;
            end
         end
         S_POP: begin
            ch_rd_nx[c_cnt] = cur_valid;
            if (abort) begin
               state_nx = S_IDLE;
            end else if (cur_valid) begin
               state_nx = mode_q ? S_RD : S_WR;
            end
         end
         S_RD: begin
            cen_nx   = 1'b0;
            addr_nx  = elem_addr;
            state_nx = abort ? S_IDLE : S_WR;
         end
         S_WR: begin
            cen_nx  = 1'b0;
            wen_nx  = 1'b0;
            addr_nx = elem_addr;
            d_nx    = mode_q ? acc_sum : cap_data;
            if (abort) begin
               state_nx = S_IDLE;
            end else begin
               state_nx = last_elem ? S_FIN : S_POP;
            end
         end
         S_FIN: begin
            done     = !abort;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign bus.ch_rd     = ch_rd_nx;
   assign bus.sram_cen  = cen_nx;
   assign bus.sram_wen  = wen_nx;
   assign bus.sram_addr = addr_nx;
   assign bus.sram_d    = d_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // The running element address replaces base + v*NUM_CH + c; ADDR_W overflow gives the wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= 1'b0;
         num_vec_q <= '0;
         v_cnt     <= '0;
         c_cnt     <= '0;
         elem_addr <= '0;
         cap_data  <= '0;
         ovf       <= 1'b0;
      end else begin
         if (accept) begin
            mode_q    <= acc_mode;
            num_vec_q <= num_vec;
            elem_addr <= base_addr;
            v_cnt     <= '0;
            c_cnt     <= '0;
            ovf       <= 1'b0;
         end
         if (state == S_POP && cur_valid) begin
            cap_data <= ch_vec[c_cnt];
         end
         if (state == S_WR) begin
            if (mode_q && |lane_sat) begin
               ovf <= 1'b1;
            end
            elem_addr <= elem_addr + ADDR_W'(1);
            if (c_cnt == CW'(NUM_CH - 1)) begin
               c_cnt <= '0;
               v_cnt <= v_cnt + ADDR_W'(1);
            end else begin
               c_cnt <= c_cnt + CW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_psum_accum_writeback.sv
// tb/tb_psum_accum_writeback.sv - randomized self-checking bench with OFIFO/SRAM models and element scoreboard
module tb_psum_accum_writeback;
   localparam int NUM_CH  = 4;
   localparam int COL     = 4;
   localparam int PSUM_BW = 16;
   localparam int ADDR_W  = 11;
   localparam int DW      = COL * PSUM_BW;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int MAXV    = (1 << (PSUM_BW - 1)) - 1;
   localparam int MINV    = -(1 << (PSUM_BW - 1));

   typedef logic [DW-1:0] vec_t;
   typedef struct {
      logic [ADDR_W-1:0] addr;
      vec_t              vec;
      bit                acc;
   } elem_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              acc_mode = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] num_vec = '0;
   logic              busy, done, ovf;

   psum_accum_writeback_if #(.NUM_CH(NUM_CH), .COL(COL), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W)) bus ();

   psum_accum_writeback #(.NUM_CH(NUM_CH), .COL(COL), .PSUM_BW(PSUM_BW), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .acc_mode(acc_mode),
      .base_addr(base_addr), .num_vec(num_vec), .bus(bus),
      .busy(busy), .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   vec_t  mem     [DEPTH];
   vec_t  ref_mem [DEPTH];
   vec_t  chq     [NUM_CH][$];
   elem_t exp_q   [$];
   bit    exp_ovf = 1'b0;
   bit    rd_seen = 1'b0;
   bit    rand_mask = 1'b0;
   logic [NUM_CH-1:0] mask = '1;
   logic [NUM_CH-1:0] rd_s = '0;
   int    pop_cnt = 0;
   int    done_cnt = 0;

   function automatic vec_t sat_add(vec_t a, vec_t b, output bit sat);
      vec_t r;
      int   x;
      sat = 1'b0;
      r   = '0;
      for (int l = 0; l < COL; l++) begin
         x = $signed(a[l*PSUM_BW +: PSUM_BW]) + $signed(b[l*PSUM_BW +: PSUM_BW]);
         if (x > MAXV) begin x = MAXV; sat = 1'b1; end
         if (x < MINV) begin x = MINV; sat = 1'b1; end
         r[l*PSUM_BW +: PSUM_BW] = x[PSUM_BW-1:0];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (!bus.sram_cen) begin
         if (!bus.sram_wen) mem[bus.sram_addr] = bus.sram_d;
         else bus.sram_q <= mem[bus.sram_addr];
      end
   end

   // OFIFO heads change a little after the edge so the DUT never races a pop.
   always @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_s[c] && chq[c].size() > 0) void'(chq[c].pop_front());
      end
      rd_s = '0;
      if (rand_mask) mask = NUM_CH'($urandom);
      #2;
      for (int c = 0; c < NUM_CH; c++) begin
         bus.ch_valid[c] = mask[c] && (chq[c].size() > 0);
         bus.ch_data[c*DW +: DW] = (chq[c].size() > 0) ? chq[c][0] : '0;
      end
   end

   always @(negedge clk) begin
      rd_s = bus.ch_rd;
      if (bus.ch_rd != '0) begin
         pop_cnt++;
         check("ch_rd_onehot", $countones(bus.ch_rd), 1);
         check("ch_rd_when_valid", |(bus.ch_rd & ~bus.ch_valid), 0);
      end
      if (done) done_cnt++;
   end

   always @(negedge clk) begin
      elem_t e;
      vec_t  want;
      bit    sat;
      if (rst_n) begin
         if (exp_q.size() == 0) begin
            check("sram_idle_cen", bus.sram_cen, 1);
         end else if (!bus.sram_cen) begin
            check("sram_addr", bus.sram_addr, exp_q[0].addr);
            if (!exp_q[0].acc) check("ovw_no_read", bus.sram_wen, 0);
            if (bus.sram_wen) begin
               rd_seen = 1'b1;
            end else begin
               e = exp_q.pop_front();
               sat = 1'b0;
               if (e.acc) begin
                  check("acc_read_first", rd_seen, 1);
                  want = sat_add(ref_mem[e.addr], e.vec, sat);
               end else begin
                  want = e.vec;
               end
               check("sram_d", bus.sram_d, want);
               ref_mem[e.addr] = want;
               if (sat) exp_ovf = 1'b1;
               rd_seen = 1'b0;
            end
         end
      end
   end

   task automatic preload(int a, vec_t val);
      mem[a]     = val;
      ref_mem[a] = val;
   endtask

   // pat 0: random lanes; 1: every lane 16*v+c; 2: lane0 +100, lane1 -100, rest 0.
   task automatic load_job(bit acc, int base, int nv, int pat, int load_v);
      vec_t vec;
      elem_t e;
      for (int v = 0; v < nv; v++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            vec = '0;
            for (int l = 0; l < COL; l++) begin
               if (pat == 0) vec[l*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
               else if (pat == 1) vec[l*PSUM_BW +: PSUM_BW] = PSUM_BW'(16 * v + c);
            end
            if (pat == 2) begin
               vec[PSUM_BW-1:0]           = PSUM_BW'(100);
               vec[2*PSUM_BW-1:PSUM_BW]   = PSUM_BW'(-100);
            end
            if (v < load_v) begin
               chq[c].push_back(vec);
               e.addr = ADDR_W'(base + v * NUM_CH + c);
               e.vec  = vec;
               e.acc  = acc;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic start_job(bit acc, int base, int nv);
      @(posedge clk);
      #1;
      start     = 1'b1;
      acc_mode  = acc;
      base_addr = ADDR_W'(base);
      num_vec   = ADDR_W'(nv);
      exp_ovf   = 1'b0;
      @(posedge clk);
      #1;
      start     = 1'b0;
      acc_mode  = 1'($urandom);
      base_addr = ADDR_W'($urandom);
      num_vec   = ADDR_W'($urandom);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 1000) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      check("done_seen", done, 1);
      @(posedge clk);
      #1;
      check("done_one_cycle", done, 0);
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_ovf"}, ovf, 0);
      check({tag, "_ch_rd"}, bus.ch_rd, 0);
      check({tag, "_cen"}, bus.sram_cen, 1);
      check({tag, "_wen"}, bus.sram_wen, 1);
      check({tag, "_addr"}, bus.sram_addr, 0);
      check({tag, "_d"}, bus.sram_d, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   cyc;
      int   pops0;
      int   dones0;
      int   k;
      vec_t pv;
      bit   acc;

      for (int i = 0; i < DEPTH; i++) preload(i, {$urandom, $urandom});

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Overwrite, base 0, two vectors of 16*v+c.
      load_job(0, 0, 2, 1, 2);
      start_job(0, 0, 2);
      wait_done(cyc);
      check("ovw_cycles", cyc, 2 * NUM_CH * 2);
      check("ovw_drained", exp_q.size(), 0);
      check("ovw_ovf", ovf, 0);

      // Accumulate across the top-of-SRAM wrap.
      pv = '0;
      for (int l = 0; l < COL; l++) pv[l*PSUM_BW +: PSUM_BW] = PSUM_BW'(100);
      preload(2046, pv); preload(2047, pv); preload(0, pv); preload(1, pv);
      load_job(1, 2046, 1, 0, 1);
      start_job(1, 2046, 1);
      wait_done(cyc);
      check("acc_cycles", cyc, 3 * NUM_CH);
      check("acc_drained", exp_q.size(), 0);
      check("acc_ovf_model", ovf, exp_ovf);

      // Saturation in both directions.
      pv = '0;
      pv[PSUM_BW-1:0]         = PSUM_BW'(32760);
      pv[2*PSUM_BW-1:PSUM_BW] = PSUM_BW'(-32760);
      for (int a = 100; a < 100 + NUM_CH; a++) preload(a, pv);
      load_job(1, 100, 1, 2, 1);
      start_job(1, 100, 1);
      wait_done(cyc);
      check("sat_drained", exp_q.size(), 0);
      check("sat_ovf_set", ovf, 1);
      check("sat_ovf_model", ovf, exp_ovf);
      repeat (5) @(posedge clk);
      #1;
      check("sat_ovf_sticky", ovf, 1);

      // Channel 2 starved for five cycles; the next start clears ovf.
      mask[2] = 1'b0;
      load_job(0, 200, 1, 0, 1);
      start_job(0, 200, 1);
      check("stall_ovf_cleared", ovf, 0);
      repeat (4) @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("stall_ch_rd", bus.ch_rd, 0);
         check("stall_cen", bus.sram_cen, 1);
         check("stall_busy", busy, 1);
      end
      mask[2] = 1'b1;
      wait_done(cyc);
      check("stall_drained", exp_q.size(), 0);

      // Abort in RD of element 3, with an ignored start while busy.
      dones0 = done_cnt;
      pops0  = pop_cnt;
      load_job(1, 300, 2, 0, 1);
      start_job(1, 300, 2);
      start = 1'b1; acc_mode = 1'b0; base_addr = ADDR_W'(1000); num_vec = ADDR_W'(1);
      @(posedge clk);
      #1;
      start = 1'b0;
      k = 0;
      while (pop_cnt - pops0 < 4 && k < 100) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("abort_reached_rd", pop_cnt - pops0, 4);
      check("abort_in_rd_cen", bus.sram_cen, 0);
      check("abort_in_rd_wen", bus.sram_wen, 1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_idle", busy, 0);
      check("abort_pending", exp_q.size(), 1);
      exp_q.delete();
      pops0 = pop_cnt;
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt, dones0);
      check("abort_no_pops", pop_cnt, pops0);

      // Reset mid-WR drops outputs at once and abandons the job.
      load_job(0, 400, 1, 0, 1);
      start_job(0, 400, 1);
      k = 0;
      while (!(bus.sram_cen == 1'b0 && bus.sram_wen == 1'b0) && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("rst_reached_wr", bus.sram_wen, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid_wr");
      exp_q.delete();
      exp_ovf = 1'b0;
      for (int c = 0; c < NUM_CH; c++) chq[c].delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pops0 = pop_cnt;
      repeat (6) @(posedge clk);
      #1;
      check("rst_no_pops", pop_cnt, pops0);
      check("rst_stay_idle", busy, 0);

      // Empty job.
      pops0 = pop_cnt;
      start_job(1, 500, 0);
      wait_done(cyc);
      check("nv0_cycles", cyc, 0);
      check("nv0_no_pops", pop_cnt, pops0);

      // Random jobs with random valid gaps.
      rand_mask = 1'b1;
      for (int j = 0; j < 8; j++) begin
         acc = 1'($urandom);
         k   = $urandom_range(1, 3);
         cyc = $urandom_range(0, DEPTH - 1);
         load_job(acc, cyc, k, 0, k);
         start_job(acc, cyc, k);
         wait_done(cyc);
         check("rand_drained", exp_q.size(), 0);
         check("rand_ovf", ovf, exp_ovf);
      end
      rand_mask = 1'b0;
      mask = '1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/psum_accum_writeback.md
PSUM_ACCUM_WRITEBACK -- requirements
Module: psum_accum_writeback

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of corelet output channels drained.
REQ-002 SHALL have parameter COL, default 8, psum lanes per channel vector.
REQ-003 SHALL have parameter PSUM_BW, default 16, signed psum lane width.
REQ-004 SHALL have parameter ADDR_W, default 11, psum SRAM address width (depth 2^ADDR_W).
REQ-005 SHALL have clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have start  in  1  begin a drain job; sampled only in IDLE.
REQ-008 SHALL have abort  in  1  synchronous job cancel.
REQ-009 SHALL have acc_mode  in  1  0 = overwrite, 1 = read-add-write; latched at start.
REQ-010 SHALL have base_addr  in  ADDR_W  first SRAM address; latched at start.
REQ-011 SHALL have num_vec  in  ADDR_W  vectors per channel; latched at start.
REQ-012 SHALL have ch_valid  in  NUM_CH  per-channel OFIFO non-empty.
REQ-013 SHALL have ch_data  in  NUM_CH*COL*PSUM_BW  per-channel OFIFO head; channel c at slice [(c+1)*COL*PSUM_BW-1 : c*COL*PSUM_BW].
REQ-014 SHALL have ch_rd  out  NUM_CH  one-hot OFIFO pop.
REQ-015 SHALL have sram_cen, sram_wen  out  1 each  active-low chip/write enable.
REQ-016 SHALL have sram_addr  out  ADDR_W; sram_d  out  COL*PSUM_BW; sram_q  in  COL*PSUM_BW (valid one cycle after read).
REQ-017 SHALL have busy  out  1; done  out  1 (one-cycle pulse); ovf  out  1 (sticky saturation flag).

Function
REQ-018 FSM states SHALL be IDLE, POP, RD, WR, FIN.
REQ-019 IDLE: start=1 SHALL latch job fields, clear ovf, zero counters v (vector) and c (channel); go POP, or FIN if num_vec=0.
REQ-020 Element order SHALL be v outer, c inner, c = 0..NUM_CH-1 strictly in order; element address = (base_addr + v*NUM_CH + c) mod 2^ADDR_W.
REQ-021 POP: ch_rd[c] SHALL equal ch_valid[c] combinationally, all other bits 0; on valid, capture channel c slice and go RD (acc_mode=1) or WR (acc_mode=0); while ch_valid[c]=0, stay in POP, no pop.
REQ-022 RD: SHALL drive sram_cen=0, sram_wen=1, sram_addr=element address for one cycle, then go WR.
REQ-023 WR: SHALL drive sram_cen=0, sram_wen=0, sram_addr=element address; sram_d = captured data (overwrite) or lane-wise captured+sram_q (accumulate).
REQ-024 Accumulate SHALL be per-lane signed PSUM_BW addition, saturating to +2^(PSUM_BW-1)-1 / -2^(PSUM_BW-1); any saturating lane SHALL set ovf.
REQ-025 After WR: c increments; at c=NUM_CH-1, c wraps to 0 and v increments; after last element (v=num_vec-1, c=NUM_CH-1), go FIN, else POP.
REQ-026 FIN: done=1 for exactly one cycle, then IDLE.
REQ-027 Outside RD/WR, sram_cen=1, sram_wen=1; ch_rd=0 outside POP.
REQ-028 busy SHALL be 1 in POP, RD, WR, FIN; 0 in IDLE.
REQ-029 Throughput: 2 cycles per element overwrite, 3 per element accumulate, with channels valid; start-to-first-pop 1 cycle.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort=1 in any non-IDLE state SHALL go IDLE next edge, no done; an in-progress WR cycle completes; a POPed but unwritten element is discarded.
REQ-032 abort and start together in IDLE: abort SHALL win (stay IDLE).
REQ-033 ovf SHALL hold until next accepted start.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, v=c=0, busy=0, done=0, ovf=0, ch_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0, independent of clk.
REQ-035 reset asserted mid-job SHALL abandon the job; no further pops or SRAM writes after deassertion until a new start.

Verification
REQ-036 NUM_CH=4, overwrite, base=0, num_vec=2, all valid, ch c vector v lanes = 16*v+c -> writes addr 0..7 in order, 16 cycles start-to-done, done one cycle.
REQ-037 Accumulate, base=2046, num_vec=1, NUM_CH=4, SRAM preloaded 100 -> writes addr 2046,2047,0,1 (wrap) with lane = 100+data.
REQ-038 Accumulate, SRAM lane 32760, data 100 -> sram_d lane 32767, ovf=1; -32760 + -100 -> -32768, ovf stays 1 until next start.
REQ-039 ch_valid[2] held low 5 cycles -> FSM stalls in POP, ch_rd all zero, no SRAM access; resumes with channel 2, order preserved.
REQ-040 abort asserted in RD of element 3 -> IDLE next cycle, no done, no write to element 3 address; start while busy ignored.
REQ-041 reset pulled low during WR -> outputs at reset values same cycle; num_vec=0 job -> done one cycle after start, zero pops, zero SRAM access.
